// File: rtl/xfpga_spram_arb.sv
// Multi-channel single-port RAM: NCH requesters share one memory through a
// round-robin arbiter, with byte write masks, an L-stage read pipeline and
// optional zero-fill after reset.
module xfpga_spram_arb #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned BW           = DW,
    parameter int unsigned NCH          = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       WRITE_MODE   = "read_first",
    parameter bit          INIT_ZERO    = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NCH-1:0]              req_valid_i,
    output logic [NCH-1:0]              req_ready_o,
    input  logic [NCH*(DW/BW)-1:0]      req_we_i,
    input  logic [NCH*AW-1:0]           req_addr_i,
    input  logic [NCH*DW-1:0]           req_din_i,
    output logic [NCH-1:0]              rsp_valid_o,
    output logic [DW-1:0]               rsp_data_o,
    output logic                        init_done_o
);

    localparam int unsigned NB = DW / BW;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            init_done_q;
    logic [CW-1:0]   ptr_q, ptr_d;

    logic [NCH-1:0]  grant;
    logic [CW-1:0]   sel;
    logic [CW-1:0]   idx;
    logic            found;
    logic            accept;
    logic [NB-1:0]   sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_din;
    logic            sel_in_range;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NB-1:0]   wr_mask;
    logic            rd_en;
    logic [DW-1:0]   mem_word;
    logic [DW-1:0]   rd_word;

    logic [DW-1:0]   mem [DEPTH];

    logic [NCH-1:0]  pv_q [READ_LATENCY];
    logic [DW-1:0]   pd_q [READ_LATENCY];

    // State, init counter, init_done flag and arbiter pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT_ZERO ? StInit : StRun;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ptr_q       <= CW'(NCH - 1);
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (state_q == StRun);
            ptr_q       <= ptr_d;
        end
    end

    // Init FSM: sweep every address once, then run
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            StInit: begin
                if (init_cnt_q == AW'(DEPTH - 1)) state_d = StRun;
                else                              init_cnt_d = init_cnt_q + 1'b1;
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Round-robin grant: first valid channel after the pointer, only once init is done
    always_comb begin
        grant = '0;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(NCH); k++) begin
            idx = CW'((int'(ptr_q) + k) % int'(NCH));
            if (init_done_q && !found && req_valid_i[idx]) begin
                grant[idx] = 1'b1;
                sel        = idx;
                found      = 1'b1;
            end
        end
    end

    assign accept   = |grant;
    assign ptr_d    = accept ? sel : ptr_q;
    assign sel_we   = req_we_i[sel*NB +: NB];
    assign sel_addr = req_addr_i[sel*AW +: AW];
    assign sel_din  = req_din_i[sel*DW +: DW];

    if ((1 << AW) == DEPTH) begin : g_pow2
        assign sel_in_range = 1'b1;
    end else begin : g_npow2
        assign sel_in_range = (32'(sel_addr) < DEPTH);
    end

    // Single memory port: init sweep has priority, otherwise the granted request
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sel_addr;
        wr_data = sel_din;
        wr_mask = sel_we;
        rd_en   = 1'b0;
        if (state_q == StInit) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt_q;
            wr_data = '0;
            wr_mask = '1;
        end else if (accept) begin
            if (|sel_we) wr_en = sel_in_range;
            else         rd_en = 1'b1;
        end
    end

    // Memory array, byte-masked writes; no reset so it maps onto RAM
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wr_mask[b]) mem[wr_addr][b*BW +: BW] <= wr_data[b*BW +: BW];
            end
        end
    end

    assign mem_word = sel_in_range ? mem[sel_addr] : '0;

    // Reads never share a cycle with a write, so both templates look identical outside
    if (WRITE_MODE == "write_first") begin : g_write_first
        always_comb begin
            rd_word = mem_word;
            if (wr_en && (wr_addr == sel_addr)) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (wr_mask[b]) rd_word[b*BW +: BW] = wr_data[b*BW +: BW];
                end
            end
        end
    end else begin : g_read_first
        assign rd_word = mem_word;
    end

    // Read pipeline: stage 0 captures at accept; data only moves with a valid strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pv_q[i] <= '0;
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= rd_en ? grant : '0;
            if (rd_en) pd_q[0] <= rd_word;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pv_q[i] <= pv_q[i-1];
                if (|pv_q[i-1]) pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign req_ready_o = grant;
    assign rsp_valid_o = pv_q[READ_LATENCY-1];
    assign rsp_data_o  = pd_q[READ_LATENCY-1];
    assign init_done_o = init_done_q;

endmodule
